// File: rtl/decode_pkg.sv
// Shared decode constants: execution-unit codes, RV64IMFD opcodes, reg_control layout
// and the decoded-entry payload carried through the output queue.
package decode_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned RC_W     = 8;
    localparam int unsigned IMM32_W  = 32;

    typedef enum logic [2:0] {
        EU_ALU     = 3'd0,
        EU_MULDIV  = 3'd1,
        EU_FPU     = 3'd2,
        EU_FMULDIV = 3'd3,
        EU_BRANCH  = 3'd4,
        EU_LSU     = 3'd5,
        EU_ILLEGAL = 3'd7
    } eu_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP   = 7'b0000111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_STORE_FP  = 7'b0100111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MADD      = 7'b1000011;
    localparam logic [6:0] OPC_MSUB      = 7'b1000111;
    localparam logic [6:0] OPC_NMSUB     = 7'b1001011;
    localparam logic [6:0] OPC_NMADD     = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP     = 7'b1010011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // OP-FP funct5 groups that change unit or register-file usage
    localparam logic [4:0] F5_FMUL     = 5'b00010;
    localparam logic [4:0] F5_FDIV     = 5'b00011;
    localparam logic [4:0] F5_FSQRT    = 5'b01011;
    localparam logic [4:0] F5_FCVT_F_F = 5'b01000;
    localparam logic [4:0] F5_FCMP     = 5'b10100;
    localparam logic [4:0] F5_FCVT_W_F = 5'b11000;
    localparam logic [4:0] F5_FCVT_F_W = 5'b11010;
    localparam logic [4:0] F5_FMV_X_F  = 5'b11100;
    localparam logic [4:0] F5_FMV_F_X  = 5'b11110;

    // reg_control = {fp nibble, valid nibble}; each nibble ordered {w1, r3, r2, r1}
    localparam int unsigned RC_VALID_LSB = 0;
    localparam int unsigned RC_FP_LSB    = 4;
    localparam logic [3:0]  RF_R1 = 4'b0001;
    localparam logic [3:0]  RF_R2 = 4'b0010;
    localparam logic [3:0]  RF_R3 = 4'b0100;
    localparam logic [3:0]  RF_W1 = 4'b1000;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } imm_fmt_e;

    typedef struct packed {
        logic [REG_W-1:0]   r1_addr;
        logic [REG_W-1:0]   r2_addr;
        logic [REG_W-1:0]   r3_addr;
        logic [REG_W-1:0]   w1_addr;
        logic [RC_W-1:0]    reg_control;
        logic [IMM32_W-1:0] imm;
        eu_e                eu_type;
    } dec_t;

    function automatic logic [IMM32_W-1:0] imm_sext(input logic [INSTR_W-1:0] i,
                                                    input imm_fmt_e fmt);
        case (fmt)
            FMT_I:   return {{20{i[31]}}, i[31:20]};
            FMT_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            FMT_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            FMT_U:   return {i[31:12], 12'b0};
            FMT_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

    function automatic logic [RC_W-1:0] rc_make(input logic [3:0] valid, input logic [3:0] fp);
        logic [RC_W-1:0] rc;
        rc = '0;
        rc[RC_VALID_LSB +: 4] = valid;
        rc[RC_FP_LSB +: 4]    = fp;
        return rc;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV64IMFD decode of one instruction word into a queue entry.
module instr_decoder
    import decode_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output dec_t               dec_c
);

    logic [6:0] opc;
    logic [6:0] funct7;
    logic [4:0] funct5;
    imm_fmt_e   fmt;
    eu_e        eu;
    logic [3:0] valid;
    logic [3:0] fp;

    assign opc    = instr[6:0];
    assign funct7 = instr[31:25];
    assign funct5 = instr[31:27];

    // Unknown opcodes (including instr[1:0] != 11) fall to the illegal default
    always_comb begin
        fmt   = FMT_R;
        eu    = EU_ILLEGAL;
        valid = '0;
        fp    = '0;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U; eu = EU_ALU; valid = RF_W1;
            end
            OPC_JAL: begin
                fmt = FMT_J; eu = EU_BRANCH; valid = RF_W1;
            end
            OPC_JALR: begin
                fmt = FMT_I; eu = EU_BRANCH; valid = RF_R1 | RF_W1;
            end
            OPC_BRANCH: begin
                fmt = FMT_B; eu = EU_BRANCH; valid = RF_R1 | RF_R2;
            end
            OPC_LOAD: begin
                fmt = FMT_I; eu = EU_LSU; valid = RF_R1 | RF_W1;
            end
            OPC_LOAD_FP: begin
                fmt = FMT_I; eu = EU_LSU; valid = RF_R1 | RF_W1; fp = RF_W1;
            end
            OPC_STORE: begin
                fmt = FMT_S; eu = EU_LSU; valid = RF_R1 | RF_R2;
            end
            OPC_STORE_FP: begin
                fmt = FMT_S; eu = EU_LSU; valid = RF_R1 | RF_R2; fp = RF_R2;
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                fmt = FMT_I; eu = EU_ALU; valid = RF_R1 | RF_W1;
            end
            OPC_OP, OPC_OP_32: begin
                eu    = (funct7 == F7_MULDIV) ? EU_MULDIV : EU_ALU;
                valid = RF_R1 | RF_R2 | RF_W1;
            end
            OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin
                eu    = EU_FMULDIV;
                valid = RF_R1 | RF_R2 | RF_R3 | RF_W1;
                fp    = RF_R1 | RF_R2 | RF_R3 | RF_W1;
            end
            OPC_OP_FP: begin
                eu    = EU_FPU;
                valid = RF_R1 | RF_R2 | RF_W1;
                fp    = RF_R1 | RF_R2 | RF_W1;
                case (funct5)
                    F5_FMUL, F5_FDIV: eu = EU_FMULDIV;
                    F5_FSQRT: begin
                        eu = EU_FMULDIV; valid = RF_R1 | RF_W1; fp = RF_R1 | RF_W1;
                    end
                    F5_FCVT_F_F: begin
                        valid = RF_R1 | RF_W1; fp = RF_R1 | RF_W1;
                    end
                    F5_FCMP: fp = RF_R1 | RF_R2;
                    F5_FCVT_W_F, F5_FMV_X_F: begin
                        valid = RF_R1 | RF_W1; fp = RF_R1;
                    end
                    F5_FCVT_F_W, F5_FMV_F_X: begin
                        valid = RF_R1 | RF_W1; fp = RF_W1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        dec_c             = '0;
        dec_c.r1_addr     = instr[19:15];
        dec_c.r2_addr     = instr[24:20];
        dec_c.r3_addr     = instr[31:27];
        dec_c.w1_addr     = instr[11:7];
        dec_c.reg_control = rc_make(valid, fp);
        dec_c.imm         = imm_sext(instr, fmt);
        dec_c.eu_type     = eu;
    end

endmodule

// File: rtl/decode_pipe.sv
// Instruction decode stage: combinational decoder feeding a DEPTH-entry output queue
// with valid/ready handshakes on both sides and a synchronous flush.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int unsigned IMM_W = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned EU_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         r1_addr,
    output logic [4:0]         r2_addr,
    output logic [4:0]         r3_addr,
    output logic [4:0]         w1_addr,
    output logic [7:0]         reg_control,
    output logic [IMM_W-1:0]   imm,
    output logic [EU_W-1:0]    eu_type
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    dec_t             dec_c;
    dec_t             q [DEPTH];
    dec_t             head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             push;
    logic             pop;

    instr_decoder u_decoder (
        .instr (instr),
        .dec_c (dec_c)
    );

    assign full      = (count == CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign in_ready  = !full || out_ready;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Entry storage needs no reset: occupancy is tracked solely by count
    always_ff @(posedge clk) begin
        if (push) q[wr_ptr] <= dec_c;
    end

    assign head        = out_valid ? q[rd_ptr] : '0;
    assign r1_addr     = head.r1_addr;
    assign r2_addr     = head.r2_addr;
    assign r3_addr     = head.r3_addr;
    assign w1_addr     = head.w1_addr;
    assign reg_control = head.reg_control;
    assign imm         = IMM_W'($signed(head.imm));
    assign eu_type     = EU_W'(head.eu_type);

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter IMM_W, default 32: width of the sign-extended immediate output.
REQ-002 Parameter DEPTH, default 2, power of two, at least 2: number of output queue entries.
REQ-003 Parameter EU_W, default 3: width of the eu_type field.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  instr is presented.
REQ-007 in_ready  output  1  the block accepts instr this cycle.
REQ-008 instr  input  32  RV64IMFD instruction word.
REQ-009 flush  input  1  discard all queued and incoming instructions.
REQ-010 out_valid  output  1  the head entry is valid.
REQ-011 out_ready  input  1  the consumer takes the head entry.
REQ-012 r1_addr, r2_addr, r3_addr, w1_addr  output  5 each  register addresses (rs1, rs2, rs3 = instr[31:27], rd).
REQ-013 reg_control  output  8  bits [3:0] = valid flags for r1, r2, r3, w1; bits [7:4] = FP-file flags for r1, r2, r3, w1.
REQ-014 imm  output  IMM_W  immediate, sign-extended per format.
REQ-015 eu_type  output  EU_W  execution unit: 0 ALU, 1 MULDIV, 2 FPU, 3 FMULDIV, 4 BRANCH, 5 LSU, 7 ILLEGAL.

Function
REQ-016 Accept = in_valid & in_ready; in_ready = !full | out_ready; in_ready is independent of in_valid.
REQ-017 Decode shall be combinational on instr; the decoded result is written into the queue tail on accept.
REQ-018 Latency: accept in cycle N with an empty queue gives out_valid=1 in cycle N+1.
REQ-019 Output fields always reflect the queue head; they are zero when the queue is empty.
REQ-020 Pop = out_valid & out_ready; the head advances on the next edge.
REQ-021 Push and pop in the same cycle (including when full) leave the count unchanged.
REQ-022 Read and write pointers wrap modulo DEPTH.
REQ-023 Count range is 0..DEPTH; a push with no pop when full is impossible by REQ-016.
REQ-024 flush=1: count and pointers go to 0 on the next edge; an input accepted in the same cycle is dropped; flush has priority over push and pop.
REQ-025 Immediate formats: I, S, B, U and J are sign-extended from their MSB to IMM_W.
REQ-026 Immediate width: if IMM_W < 32, the value is truncated to its low bits; R and R4 formats give imm=0.
REQ-027 Opcode to eu_type: OP/OP-IMM/OP-32/OP-IMM-32/LUI/AUIPC map to ALU; OP/OP-32 with funct7=0000001 maps to MULDIV.
REQ-028 Opcode to eu_type: BRANCH/JAL/JALR map to BRANCH; LOAD/STORE/LOAD-FP/STORE-FP map to LSU.
REQ-029 Opcode to eu_type: OP-FP with FMUL/FDIV/FSQRT, and FMADD/FMSUB/FNMSUB/FNMADD, map to FMULDIV; any other OP-FP maps to FPU.
REQ-030 Any other opcode, or instr[1:0] != 11, gives eu_type=7 and reg_control=0; the instruction is still queued.
REQ-031 R4 format sets the r3 valid flag; FP operand and destination flags follow the F/D register-file usage (for example, FMV.X.D writes the integer file).

Reset
REQ-032 rst low shall immediately clear count, pointers and queue valid state.
REQ-033 During reset: out_valid=0, every output field 0, in_ready=1.
REQ-034 A reset asserted mid-transfer discards all entries; no partial entry appears after reset release.

Structure
REQ-035 The eu_type encodings, opcode constants and reg_control bit positions shall live in a shared package, decode_pkg.
REQ-036 Combinational decode shall be a sub-module, instr_decoder, instanced once at the input; the queue is local to decode_pipe.

Verification
REQ-037 ADDI: instr=0xFFF30293 -> r1_addr=6, w1_addr=5, imm all ones, eu_type=0, reg_control=0x09, out_valid the next cycle.
REQ-038 MUL: instr=0x023100B3 -> r1=2, r2=3, w1=1, eu_type=1, reg_control=0x0B, imm=0.
REQ-039 FMADD.D: instr=0x223170C3 -> r1=2, r2=3, r3=4, w1=1, eu_type=3, reg_control=0xFF.
REQ-040 Back-pressure: hold out_ready=0 and push 3 words -> in_ready=0 after DEPTH=2 pushes; release -> outputs in order, no loss.
REQ-041 Push+pop and flush: at full, push and pop together -> count stays 2; flush with in_valid=1 -> out_valid=0 next cycle, input dropped.
REQ-042 Illegal and reset: instr=0x00000000 -> eu_type=7, reg_control=0; rst low mid-stream -> out_valid=0 immediately and in_ready=1.
